// File: rtl/seq_multiplier_pkg.sv
// Shared op codes, FSM state encodings and the captured-request record
// for the iterative multiplier.
package seq_multiplier_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_SMULH = 2'b01;
    localparam logic [1:0] OP_UMULH = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Everything about a request that must survive the whole run.
    typedef struct packed {
        logic [1:0] op;
        logic       neg;   // SMULH only: product must be negated at the end
        logic [4:0] rd;
    } req_t;

endpackage

// File: rtl/seq_multiplier_twos_neg.sv
// Combinational two's-complement negate of a W-bit value.
module twos_neg #(
    parameter int W = 64
) (
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = ~x + {{(W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/seq_multiplier.sv
// Radix-2 shift-add multiplier for MUL / SMULH / UMULH. One step per clock,
// WIDTH steps per operation, result and Rd registered when entering DONE.
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [4:0]       rd_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       rd_out
);

    localparam int CW = $clog2(WIDTH) + 1;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    req_t               req;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] prod, prod_nxt, prod_neg, prod_sel;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   a_neg, b_neg, a_abs, b_abs, res_nxt;
    logic               accept, last, is_smulh;

    assign accept   = (state == ST_IDLE) && start;
    assign last     = (state == ST_RUN) && (cnt == CW'(1));
    assign is_smulh = (op == OP_SMULH);

    twos_neg #(.W(WIDTH))   u_neg_a (.x(a),        .y(a_neg));
    twos_neg #(.W(WIDTH))   u_neg_b (.x(b),        .y(b_neg));
    twos_neg #(.W(2*WIDTH)) u_neg_p (.x(prod_nxt), .y(prod_neg));

    assign a_abs = a[WIDTH-1] ? a_neg : a;
    assign b_abs = b[WIDTH-1] ? b_neg : b;

    // State register and step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= CW'(WIDTH);
            else if (state == ST_RUN)
                cnt <= cnt - CW'(1);
        end
    end

    // Next-state: starts are only honoured in IDLE, never queued
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_RUN;
            ST_RUN:  if (cnt == CW'(1)) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded straight from state so reset clears them at once
    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

    // One shift-add step plus final half selection; the carry out of the
    // add becomes the new product MSB after the right shift.
    always_comb begin
        sum      = {1'b0, prod[2*WIDTH-1:WIDTH]} + (mplier[0] ? {1'b0, mcand} : '0);
        prod_nxt = {sum, prod[WIDTH-1:1]};
        // neg is only ever set for SMULH, so other ops see the raw product
        prod_sel = req.neg ? prod_neg : prod_nxt;
        case (req.op)
            OP_MUL:   res_nxt = prod_sel[WIDTH-1:0];
            OP_SMULH,
            OP_UMULH: res_nxt = prod_sel[2*WIDTH-1:WIDTH];
            default:  res_nxt = '0;
        endcase
    end

    // Datapath: capture operands on accept, iterate in RUN, latch result on the last step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req    <= '0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            result <= '0;
            rd_out <= '0;
        end else if (accept) begin
            req.op  <= op;
            req.neg <= is_smulh & (a[WIDTH-1] ^ b[WIDTH-1]);
            req.rd  <= rd_in;
            mcand   <= is_smulh ? a_abs : a;
            mplier  <= is_smulh ? b_abs : b;
            prod    <= '0;
        end else if (state == ST_RUN) begin
            prod   <= prod_nxt;
            mplier <= mplier >> 1;
            if (last) begin
                result <= res_nxt;
                rd_out <= req.rd;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: expected writebacks are queued when a
// request is driven and popped when done pulses.
module tb_seq_multiplier;

    localparam int W = 64;

    typedef struct {
        logic [W-1:0] res;
        logic [4:0]   rd;
    } exp_t;

    logic         clk, rst_n, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic [4:0]   rd_in;
    logic         busy, done;
    logic [W-1:0] result;
    logic [4:0]   rd_out;

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .rd_in(rd_in), .busy(busy), .done(done), .result(result), .rd_out(rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: full-precision products via native multiply
    function automatic logic [W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0]        pu;
        logic signed [2*W-1:0] ps;
        pu = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        ps = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        case (o)
            2'b00:   model = pu[W-1:0];
            2'b01:   model = ps[2*W-1:W];
            2'b10:   model = pu[2*W-1:W];
            default: model = '0;
        endcase
    endfunction

    // Drive one request from an IDLE negedge, wait for done, check it
    // against the scoreboard; returns at the IDLE negedge after done.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input logic [4:0] r);
        exp_t e;
        int   cyc = 0;
        int   busy_bad = 0;
        bit   seen = 0;
        e.res = model(o, x, y);
        e.rd  = r;
        sb.push_back(e);
        start = 1'b1; op = o; a = x; b = y; rd_in = r;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                start = 1'b0;
                a = {$urandom, $urandom}; b = {$urandom, $urandom};
                op = 2'($urandom_range(0, 3)); rd_in = 5'($urandom_range(0, 31));
            end
            if (done) seen = 1;
            else if (!busy) busy_bad++;
        end
        e = sb.pop_front();
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
        end else begin
            n_tests++;
            if (cyc - 1 !== W) begin
                n_fail++;
                $display("FAIL %s latency: got %0d edges, expected %0d", name, cyc - 1, W);
            end
            n_tests++;
            if (busy_bad !== 0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s busy: low in %0d run cycles, busy at done=%b, expected 1", name, busy_bad, busy);
            end
            if (result !== e.res) begin
                n_fail++;
                $display("FAIL %s result: got %h expected %h", name, result, e.res);
            end
            n_tests++;
            if (rd_out !== e.rd) begin
                n_fail++;
                $display("FAIL %s rd_out: got %0d expected %0d", name, rd_out, e.rd);
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL %s after-done: done=%b busy=%b result=%h rd=%0d, expected 0 0 %h %0d",
                     name, done, busy, result, rd_out, e.res, e.rd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_in = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b done=%b result=%h rd=%0d, expected all 0", busy, done, result, rd_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle after reset: busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_mul_basic();
        run_op("mul_3x5", 2'b00, 64'd3, 64'd5, 5'd9);
        n_tests++;
        if (result !== 64'd15) begin
            n_fail++;
            $display("FAIL mul_3x5 const: got %h expected 15", result);
        end
    endtask

    task automatic test_all_ones();
        run_op("umulh_ones", 2'b10, '1, '1, 5'd1);
        n_tests++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFE) begin
            n_fail++;
            $display("FAIL umulh_ones const: got %h expected FFFFFFFFFFFFFFFE", result);
        end
        run_op("mul_ones", 2'b00, '1, '1, 5'd2);
        n_tests++;
        if (result !== 64'h1) begin
            n_fail++;
            $display("FAIL mul_ones const: got %h expected 1", result);
        end
    endtask

    task automatic test_smulh();
        run_op("smulh_m1x1", 2'b01, '1, 64'd1, 5'd31);
        n_tests++;
        if (result !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            n_fail++;
            $display("FAIL smulh_m1x1 const: got %h expected FFFFFFFFFFFFFFFF", result);
        end
        run_op("smulh_min", 2'b01, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 5'd7);
        n_tests++;
        if (result !== 64'h4000_0000_0000_0000) begin
            n_fail++;
            $display("FAIL smulh_min const: got %h expected 4000000000000000", result);
        end
        run_op("smulh_neg_mixed", 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'h7FFF_FFFF_FFFF_FFFF, 5'd8);
    endtask

    // Starts during RUN and in the done cycle are dropped; the held start
    // is taken in the first IDLE cycle after done.
    task automatic test_back_to_back();
        exp_t e;
        int   cyc = 0;
        bit   seen = 0;
        e.res = 64'd14; e.rd = 5'd2;
        sb.push_back(e);
        start = 1'b1; op = 2'b00; a = 64'd2; b = 64'd7; rd_in = 5'd2;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1)  start = 1'b0;
            if (cyc == 10) begin start = 1'b1; a = 64'd9; b = 64'd9; rd_in = 5'd4; end
            if (cyc == 11) start = 1'b0;
            if (cyc == 64) start = 1'b1;
            if (done) seen = 1;
        end
        e = sb.pop_front();
        n_tests++;
        if (!seen || cyc - 1 !== W || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL b2b first: seen=%b edges=%0d result=%h rd=%0d, expected 1 %0d %h %0d",
                     seen, cyc - 1, result, rd_out, W, e.res, e.rd);
        end
        // start still high into the IDLE cycle: this one must be taken
        e.res = 64'd81; e.rd = 5'd4;
        sb.push_back(e);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || result !== 64'd14) begin
            n_fail++;
            $display("FAIL b2b idle gap: busy=%b result=%h expected 0 %h", busy, result, 64'd14);
        end
        cyc = 0; seen = 0;
        while (cyc < 200 && !seen) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done) seen = 1;
        end
        e = sb.pop_front();
        n_tests++;
        if (!seen || cyc - 1 !== W || result !== e.res || rd_out !== e.rd) begin
            n_fail++;
            $display("FAIL b2b second: seen=%b edges=%0d result=%h rd=%0d, expected 1 %0d %h %0d",
                     seen, cyc - 1, result, rd_out, W, e.res, e.rd);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midrun();
        int extra = 0;
        start = 1'b1; op = 2'b00; a = 64'd7; b = 64'd7; rd_in = 5'd5;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) start = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== '0 || rd_out !== 5'd0) begin
            n_fail++;
            $display("FAIL midrun reset: busy=%b done=%b result=%h rd=%0d, expected all 0", busy, done, result, rd_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        n_tests++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL midrun no-writeback: %0d busy/done cycles after reset, expected 0", extra);
        end
        run_op("mul_4x4_after_reset", 2'b00, 64'd4, 64'd4, 5'd6);
        n_tests++;
        if (result !== 64'd16) begin
            n_fail++;
            $display("FAIL mul_4x4 const: got %h expected 16", result);
        end
    endtask

    task automatic test_reserved();
        run_op("rsvd", 2'b11, 64'd5, 64'd5, 5'd3);
        n_tests++;
        if (result !== '0 || rd_out !== 5'd3) begin
            n_fail++;
            $display("FAIL rsvd const: result=%h rd=%0d expected 0 3", result, rd_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++)
            run_op("random", 2'(i % 3), {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(0, 31)));
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_all_ones();
        test_smulh();
        test_back_to_back();
        test_reset_midrun();
        test_reserved();
        test_random();
        n_tests++;
        if (sb.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard leftover: %0d entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
